// File: rtl/fetch_unit_pkg.sv
// Shared core package: fetch FSM encoding, fetch payload and reset constants.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    // Default first-fetch address after reset.
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    // Default bubble instruction: addi x0,x0,0.
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Clears the byte offset of a fetch address.
    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;
    // Distance between sequential instructions.
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    // Fetch FSM states.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request in flight on the bus, waiting for ACK
        ST_WAIT  = 2'd1,  // request accepted, waiting for RVALID
        ST_DROP  = 2'd2,  // one stale response still owed by memory
        ST_BLOCK = 2'd3   // skid entry occupied, no new request
    } fetch_state_e;

    // One fetched instruction together with its address.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Word-align an address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding a fetched {pc, instruction} while decode stalls.
module fetch_skid_buffer
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic         valid,
    output fetch_entry_t entry
);

    logic         valid_q;
    logic         valid_d;
    fetch_entry_t entry_q;
    fetch_entry_t entry_d;

    // Next-entry selection: clear beats push, push beats pop.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            entry_d = push_entry;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid = valid_q;
    assign entry = entry_q;

endmodule : fetch_skid_buffer

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, registered IF outputs,
// one-entry skid buffer for decode back-pressure, redirect with stale-response drop.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL,
    input  logic            REDIRECT,
    input  logic [XLEN-1:0] REDIRECT_PC,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    input  logic            IMEM_ACK,
    input  logic            IMEM_RVALID,
    input  logic [XLEN-1:0] IMEM_RDATA,
    output logic [XLEN-1:0] IF_PC,
    output logic [XLEN-1:0] IF_PC_PLUS4,
    output logic [XLEN-1:0] IF_INSTRUCTION,
    output logic            IF_VALID
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    logic            if_valid_q;
    logic            if_valid_d;
    logic [XLEN-1:0] if_pc_q;
    logic [XLEN-1:0] if_pc_d;
    logic [XLEN-1:0] if_pc_plus4_q;
    logic [XLEN-1:0] if_pc_plus4_d;
    logic [XLEN-1:0] if_instr_q;
    logic [XLEN-1:0] if_instr_d;

    logic            skid_valid;
    fetch_entry_t    skid_entry;
    logic            skid_clear;
    logic            skid_push;
    logic            skid_pop;

    logic            imem_req_c;
    logic            captured_c;
    logic            out_ready_c;
    fetch_entry_t    capture_entry_c;

    // Request is gated by reset so memory never sees a request during RST.
    assign imem_req_c = !RST && (state_q == ST_FETCH) && !skid_valid;
    assign IMEM_REQ   = imem_req_c;
    // pc_q is only ever loaded with word-aligned values.
    assign IMEM_ADDR  = pc_q;

    // A response is captured only when it belongs to the live request.
    assign captured_c            = (state_q == ST_WAIT) && IMEM_RVALID;
    // Output register may take new data when empty or when decode is consuming.
    assign out_ready_c           = !if_valid_q || !STALL;
    assign capture_entry_c.pc    = pc_q;
    assign capture_entry_c.instr = IMEM_RDATA;

    // Next-state, PC and IF output register computation; REDIRECT overrides all.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        skid_clear = 1'b0;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;

        if (REDIRECT) begin
            pc_d       = word_align(REDIRECT_PC);
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            skid_clear = 1'b1;
            case (state_q)
                // A response still owed by memory must be swallowed unless it is arriving now.
                ST_WAIT,
                ST_DROP:  state_d = IMEM_RVALID ? ST_FETCH : ST_DROP;
                // A request accepted this very cycle becomes a stale response.
                ST_FETCH: state_d = (imem_req_c && IMEM_ACK) ? ST_DROP : ST_FETCH;
                ST_BLOCK: state_d = ST_FETCH;
            endcase
        end else begin
            if (out_ready_c) begin
                if (skid_valid) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = skid_entry.pc;
                    if_instr_d = skid_entry.instr;
                    skid_pop   = 1'b1;
                end else if (captured_c) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = capture_entry_c.pc;
                    if_instr_d = capture_entry_c.instr;
                end else begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end
            end else if (captured_c) begin
                skid_push = 1'b1;
            end

            case (state_q)
                ST_FETCH: begin
                    if (imem_req_c && IMEM_ACK) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (IMEM_RVALID) begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = out_ready_c ? ST_FETCH : ST_BLOCK;
                    end
                end
                ST_DROP: begin
                    if (IMEM_RVALID) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_BLOCK: begin
                    if (out_ready_c) begin
                        state_d = ST_FETCH;
                    end
                end
            endcase
        end

        // Kept in lockstep with the PC so it is always IF_PC+4.
        if_pc_plus4_d = if_pc_d + PC_STEP;
    end

    // State, PC and IF output registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= RESET_PC;
            if_pc_plus4_q <= RESET_PC + PC_STEP;
            if_instr_q    <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_instr_q    <= if_instr_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk        (CLK),
        .rst        (RST),
        .clear      (skid_clear),
        .push       (skid_push),
        .push_entry (capture_entry_c),
        .pop        (skid_pop),
        .valid      (skid_valid),
        .entry      (skid_entry)
    );

    assign IF_VALID       = if_valid_q;
    assign IF_PC          = if_pc_q;
    assign IF_PC_PLUS4    = if_pc_plus4_q;
    assign IF_INSTRUCTION = if_instr_q;

endmodule : fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC fetched first after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the instruction driven whenever no valid instruction is presented.
REQ-003 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 STALL  in  1  decode cannot accept this cycle; the presented instruction shall be held.
REQ-006 REDIRECT  in  1  taken branch or jump from execute; one-cycle pulse.
REQ-007 REDIRECT_PC  in  32  redirect target; bits [1:0] ignored.
REQ-008 IMEM_REQ  out  1  instruction-memory read request.
REQ-009 IMEM_ADDR  out  32  word-aligned read address, bits [1:0] always 0.
REQ-010 IMEM_ACK  in  1  memory accepted the request this cycle.
REQ-011 IMEM_RVALID  in  1  read data valid; never in the same cycle as the ACK of the same request.
REQ-012 IMEM_RDATA  in  32  instruction word.
REQ-013 IF_PC, IF_PC_PLUS4, IF_INSTRUCTION  out  32 each  fetched PC, PC+4, and instruction word to decode.
REQ-014 IF_VALID  out  1  the IF_* outputs carry a real instruction; 0 means bubble.

Function
REQ-015 The unit SHALL keep at most one memory request outstanding.
REQ-016 The FSM SHALL have four states:
- FETCH: IMEM_REQ=1 and IMEM_ADDR=PC; on ACK go to WAIT.
- WAIT: await RVALID.
- DROP: discard one stale response.
- BLOCK: skid full, no request issued.
REQ-017 FETCH SHALL assert IMEM_REQ only while the skid buffer is empty; IMEM_REQ and IMEM_ADDR SHALL stay stable until ACK.
REQ-018 On RVALID in WAIT, the instruction SHALL be captured with its PC, PC SHALL advance by 4 (mod 2^32), and the FSM SHALL return to FETCH.
REQ-019 The output register SHALL load the captured instruction when it is empty or STALL=0; otherwise the instruction SHALL go to the 1-entry skid buffer.
REQ-020 When the skid buffer fills, the FSM SHALL enter BLOCK.
REQ-021 With STALL=0, the skid entry SHALL move to the output register and BLOCK SHALL exit to FETCH in the same cycle.
REQ-022 With STALL=1 and IF_VALID=1, all IF_* outputs SHALL hold their values unchanged.
REQ-023 When IF_VALID=0, IF_INSTRUCTION SHALL equal NOP_INSTR.
REQ-024 With STALL=0 and no new instruction available, IF_VALID SHALL fall to 0.
REQ-025 IF_PC_PLUS4 SHALL always equal IF_PC+4.
REQ-026 On REDIRECT, regardless of STALL, the unit SHALL apply all of the following in the next cycle:
- PC <= {REDIRECT_PC[31:2],2'b00};
- IF_VALID <= 0;
- skid buffer cleared.
REQ-027 The post-REDIRECT state SHALL be DROP if a response is outstanding (WAIT, or FETCH with ACK in the same cycle), else FETCH.
REQ-028 REDIRECT coincident with RVALID SHALL discard that response and go to FETCH.
REQ-029 In DROP, the next RVALID SHALL be discarded without updating PC or outputs, then the FSM SHALL go to FETCH; a further REDIRECT while in DROP SHALL only update PC.
REQ-030 REDIRECT SHALL have priority over STALL and RVALID; RST SHALL have priority over everything.
REQ-031 Best-case throughput SHALL be one instruction per 2 cycles with single-cycle memory response latency; a response SHALL reach IF_* one cycle after RVALID.

Reset
REQ-032 While RST=1 at a clock edge, the unit SHALL set state=FETCH, PC=RESET_PC, skid empty.
REQ-033 While RST=1 at a clock edge, the unit SHALL set IF_VALID=0, IF_INSTRUCTION=NOP_INSTR, IF_PC=RESET_PC, IF_PC_PLUS4=RESET_PC+4.
REQ-034 IMEM_REQ SHALL be 0 in any cycle where RST=1.
REQ-035 Reset mid-transaction SHALL abandon any outstanding request; instruction memory shares RST.

Structure
REQ-036 RESET_PC, NOP_INSTR and the FSM state encoding SHALL live in the shared core package.
REQ-037 The skid buffer SHALL be one sub-module, FETCH_SKID_BUFFER, holding 1 entry of {PC, instruction}; the FSM and PC register SHALL stay in fetch_unit.

Verification
REQ-038 Reset release, 1-cycle-latency memory returning 0x00500093 at PC 0 -> first valid cycle shows IF_PC=0, IF_PC_PLUS4=4, IF_INSTRUCTION=0x00500093, IF_VALID=1; next fetch at 4.
REQ-039 STALL=1 for 3 cycles while a response arrives -> IF_* frozen, response held in skid, IMEM_REQ=0 during BLOCK; after STALL drops, both instructions appear in order with no loss or duplication.
REQ-040 REDIRECT to 0x0000_0102 while in WAIT -> stale RVALID discarded, next IMEM_ADDR=0x0000_0100, IF_VALID=0 until the new word returns.
REQ-041 REDIRECT coincident with RVALID and STALL=1 -> response dropped, skid cleared, IF_VALID=0, fetch resumes at the target.
REQ-042 PC at 0xFFFF_FFFC -> next IMEM_ADDR=0x0000_0000, and IF_PC_PLUS4=0x0000_0000 for that instruction.
REQ-043 RST asserted during WAIT -> next cycle IF_VALID=0, IF_INSTRUCTION=0x00000013, IMEM_REQ=0; then the fetch restarts at RESET_PC.
